byte_pair_packer: RTL and testbench
===================================

# byte_pair_packer

Collects an 8-bit byte stream into 16-bit words with valid/ready handshakes on both sides. It sits directly upstream of the 16-bit byte-lane swap stage and drives that stage's 16-bit input `a` from `out_data`. The first byte of each pair occupies `out_data[15:8]` and the second occupies `out_data[7:0]`. A flush input closes an odd trailing byte by padding it.

## Interface
- `PAD_BYTE`, default 8'h00: value placed in `out_data[7:0]` when a half word is flushed.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_data` input 8: incoming byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: packer accepts a byte this cycle. Combinational.
- `flush` input 1: single-cycle request to emit a held half word.
- `out_data` output 16: packed word, registered.
- `out_valid` output 1: `out_data` is valid, registered.
- `out_ready` input 1: downstream accepts the word.
- `out_partial` output 1: the current word was padded by a flush. Registered; meaningful only while `out_valid`=1.
- `word_count` output 16: number of completed output handshakes since reset. Wraps at 16'hFFFF.

## Operation
- **Handshakes.** An input byte is accepted when `in_valid && in_ready`. An output word is accepted when `out_valid && out_ready`.
- **`in_ready` rule.** `in_ready = (state != FULL) || out_ready`. It may depend combinationally on `out_ready`. It never depends on `in_valid`.
- **State machine.** States are IDLE (nothing held), HALF (high byte held in `hi_reg`) and FULL (word presented).
- **IDLE:**
  - Accepted byte → `hi_reg` ← `in_data`; go to HALF.
  - `flush` → ignored.
- **HALF:**
  - Accepted byte → `out_data` ← {`hi_reg`, `in_data`}, `out_partial` ← 0, `out_valid` ← 1; go to FULL.
  - `flush` asserted with no accepted byte → `out_data` ← {`hi_reg`, `PAD_BYTE`}, `out_partial` ← 1, `out_valid` ← 1; go to FULL.
  - `flush` asserted together with an accepted byte → the byte completes the word normally and the flush is dropped.
- **FULL:**
  - Output handshake with no accepted byte → `out_valid` ← 0; go to IDLE.
  - Output handshake plus accepted byte in the same cycle → `out_valid` ← 0, `hi_reg` ← `in_data`; go to HALF.
  - No output handshake → `in_ready` = 0; `out_data`, `out_partial` and `out_valid` hold stable.
  - `flush` → ignored.
- **Flush is not sticky.** It is evaluated only in the cycle it is asserted.
- **`word_count`** increments by 1 on every output handshake. 16'hFFFF + 1 = 16'h0000, no saturation.
- **`out_data` contents** are unchanged after a handshake until the next word loads. Downstream must qualify them with `out_valid`.
- **Reset:**
  - `rst_n` low forces state IDLE, `hi_reg` = 8'h00, `out_data` = 16'h0000, `out_valid` = 0, `out_partial` = 0 and `word_count` = 16'h0000, immediately and without waiting for a clock edge.
  - `in_ready` reads 1 during reset, because state is IDLE.
  - Reset in HALF or FULL discards the held byte or word. No output handshake is counted for it.

## Timing
- **Latency.** The second byte is accepted at edge k; `out_valid` = 1 in the cycle after edge k. Flush follows the same rule: flush at edge k gives `out_valid` in the cycle after edge k.
- **Throughput.**
  - With `out_ready` tied high and `in_valid` continuous, `in_ready` stays 1, one byte is accepted per cycle and one word is produced every 2 cycles.
  - State sequence: IDLE, HALF, FULL, HALF, FULL, …
- **Backpressure.** With `out_ready` = 0 in FULL, no byte is accepted. At most one word plus zero bytes are buffered in that case.
- **Combinational paths.** The only combinational path is `out_ready` → `in_ready`. There is none from `in_valid` to any output.
- **Reset release.** Deassertion of `rst_n` is assumed synchronous to `clk` at system level. The first accepted byte can occur at the first rising edge after release.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-stream with the packer in FULL holding 16'hABCD. Expect `out_valid`=0, `out_data`=16'h0000, `word_count`=0 and `in_ready`=1 immediately, before the next clock.
- **Basic pack.** Bytes 8'h12 then 8'h34 with `out_ready`=1. Expect `out_data`=16'h1234, `out_partial`=0 and `out_valid` for exactly one cycle; `word_count` goes 0→1.
- **Streaming.** 8 continuous bytes 8'h01…8'h08 with `out_ready`=1. Expect `in_ready` always 1 and words 16'h0102, 16'h0304, 16'h0506, 16'h0708 on alternate cycles; `word_count`=4.
- **Backpressure.** Complete word 16'hA5C3, hold `out_ready`=0 for 5 cycles while `in_valid`=1 with 8'h77. Expect `in_ready`=0 and `out_data` stable for those 5 cycles. Raise `out_ready` and expect the handshake; 8'h77 is accepted in the same cycle and the state moves to HALF.
- **Flush.** With `PAD_BYTE`=8'hEE, accept byte 8'h5A, then pulse `flush` with `in_valid`=0. Expect `out_data`=16'h5AEE and `out_partial`=1. Pulsing `flush` in IDLE produces no word. `flush` together with byte 8'h6B from HALF holding 8'h5A yields 16'h5A6B with `out_partial`=0.
- **Counter wrap.** Preload by driving 65 536 words. Expect `word_count` to go 16'hFFFF→16'h0000 on the last handshake.

Source files
------------

// File: rtl/byte_pair_packer_if.sv
// Handshake bundle between the byte-stream source, the packer and the 16-bit consumer.
// The slave modport is the packer's view; the master modport is the environment's view.
interface byte_pair_packer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_partial;
  logic [15:0] word_count;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, out_partial, word_count
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, out_partial, word_count
  );
endinterface

// File: rtl/byte_pair_packer.sv
// Packs an 8-bit byte stream into 16-bit words (first byte high), with flush padding
// of an odd trailing byte and a wrapping count of completed output handshakes.
module byte_pair_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input logic              clk,
  input logic              rst_n,
  byte_pair_packer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_hi;
  logic [15:0] r_out_data;
  logic        r_out_valid;
  logic        r_out_partial;
  logic [15:0] r_word_count;

  state_t      w_state_nxt;
  logic [7:0]  w_hi_nxt;
  logic [15:0] w_out_data_nxt;
  logic        w_out_valid_nxt;
  logic        w_out_partial_nxt;
  logic [15:0] w_word_count_nxt;
  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_out_fire;

  // Only combinational path: a word leaving this cycle frees room for a byte.
  assign w_in_ready = (r_state != FULL) || bus.out_ready;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_hi_nxt          = r_hi;
    w_out_data_nxt    = r_out_data;
    w_out_valid_nxt   = r_out_valid;
    w_out_partial_nxt = r_out_partial;
    w_word_count_nxt  = r_word_count + {15'd0, w_out_fire};
    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_hi_nxt    = bus.in_data;
          w_state_nxt = HALF;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HALF: begin
        // A real byte wins over a simultaneous flush.
        if (w_in_fire) begin
          w_out_data_nxt    = {r_hi, bus.in_data};
          w_out_partial_nxt = 1'b0;
          w_out_valid_nxt   = 1'b1;
          w_state_nxt       = FULL;
        end else if (bus.flush) begin
          w_out_data_nxt    = {r_hi, PAD_BYTE};
          w_out_partial_nxt = 1'b1;
          w_out_valid_nxt   = 1'b1;
          w_state_nxt       = FULL;
        end else begin
          w_state_nxt = HALF;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_out_valid_nxt = 1'b0;
          if (w_in_fire) begin
            w_hi_nxt    = bus.in_data;
            w_state_nxt = HALF;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = FULL;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_hi          <= 8'h00;
      r_out_data    <= 16'h0000;
      r_out_valid   <= 1'b0;
      r_out_partial <= 1'b0;
      r_word_count  <= 16'h0000;
    end else begin
      r_state       <= w_state_nxt;
      r_hi          <= w_hi_nxt;
      r_out_data    <= w_out_data_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_partial <= w_out_partial_nxt;
      r_word_count  <= w_word_count_nxt;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_partial = r_out_partial;
  assign bus.word_count  = r_word_count;

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer: reset, pairing, streaming, backpressure,
// flush padding, mid-stream reset and word counter wrap.
module tb_byte_pair_packer;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  byte_pair_packer_if bus ();

  byte_pair_packer #(.PAD_BYTE(8'hEE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.out_data}, 32'h0000);
    chk("rst_partial", {31'd0, bus.out_partial}, 32'd0);
    chk("rst_count", {16'd0, bus.word_count}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Basic pack 12,34
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h12;
    #1;
    chk("basic_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_data = 8'h34;
    #1;
    chk("basic_valid_early", {31'd0, bus.out_valid}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("basic_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("basic_data", {16'd0, bus.out_data}, 32'h1234);
    chk("basic_partial", {31'd0, bus.out_partial}, 32'd0);
    chk("basic_count0", {16'd0, bus.word_count}, 32'd0);
    tick();
    #1;
    chk("basic_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("basic_count1", {16'd0, bus.word_count}, 32'd1);

    // Streaming 01..08 with out_ready high
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(i + 1);
      bus.in_data = b;
      #1;
      chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (i >= 2 && (i % 2) == 0) begin
        chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stream_data", {16'd0, bus.out_data}, {16'd0, 8'(i - 1), 8'(i)});
      end else begin
        chk("stream_idle", {31'd0, bus.out_valid}, 32'd0);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("stream_last_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stream_last_data", {16'd0, bus.out_data}, 32'h0708);
    tick();
    #1;
    chk("stream_count", {16'd0, bus.word_count}, 32'd5);

    // Backpressure on word A5C3 with byte 77 waiting
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    tick();
    bus.in_data = 8'hC3;
    tick();
    bus.in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_data", {16'd0, bus.out_data}, 32'hA5C3);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("bp_after_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_count", {16'd0, bus.word_count}, 32'd6);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h01;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("bp_held_byte", {16'd0, bus.out_data}, 32'h7701);
    tick();

    // Flush a half word
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("flush_data", {16'd0, bus.out_data}, 32'h5AEE);
    chk("flush_partial", {31'd0, bus.out_partial}, 32'd1);
    tick();
    #1;
    chk("flush_count", {16'd0, bus.word_count}, 32'd8);
    // Flush in IDLE is ignored
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    #1;
    chk("flush_idle_valid2", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_idle_count", {16'd0, bus.word_count}, 32'd8);
    // Flush together with a byte completes normally
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    tick();
    bus.in_data = 8'h6B;
    bus.flush = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("flushbyte_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("flushbyte_data", {16'd0, bus.out_data}, 32'h5A6B);
    chk("flushbyte_partial", {31'd0, bus.out_partial}, 32'd0);
    tick();
    #1;
    chk("flushbyte_count", {16'd0, bus.word_count}, 32'd9);

    // Asynchronous reset while FULL holds ABCD
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAB;
    tick();
    bus.in_data = 8'hCD;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("prerst_data", {16'd0, bus.out_data}, 32'hABCD);
    chk("prerst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_data", {16'd0, bus.out_data}, 32'h0000);
    chk("arst_count", {16'd0, bus.word_count}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("postrst_valid", {31'd0, bus.out_valid}, 32'd0);

    // Counter wrap: preload near the top, then complete three words
    bus.out_ready = 1'b1;
    force dut.r_word_count = 16'hFFFD;
    tick();
    release dut.r_word_count;
    #1;
    chk("wrap_preload", {16'd0, bus.word_count}, 32'hFFFD);
    for (int w = 0; w < 3; w++) begin
      logic [15:0] exp_cnt;
      exp_cnt = 16'hFFFE + 16'(w);
      bus.in_valid = 1'b1;
      bus.in_data = 8'h10;
      tick();
      bus.in_data = 8'h20;
      tick();
      bus.in_valid = 1'b0;
      tick();
      #1;
      chk("wrap_count", {16'd0, bus.word_count}, {16'd0, exp_cnt});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
